alu_packet_engine: RTL and testbench

//   Command engine between the UART receiver and transmitter inside uart_alu.

---
 rtl/alu_packet_engine.sv | 196 +++++++++++++++++++
 tb/tb_alu_packet_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_packet_engine.sv
// Command engine between the UART receiver and transmitter inside uart_alu.
// Parses length-framed packets from the RX byte stream, executes ECHO / ADD32 /
// SUB32 and streams response bytes to the transmitter over valid/ready.
// RX is never back-pressured: bytes that cannot be taken are dropped with an error pulse.
module alu_packet_engine #(
    parameter logic [7:0] OPC_ECHO = 8'hEC,
    parameter logic [7:0] OPC_ADD  = 8'hAD,
    parameter logic [7:0] OPC_SUB  = 8'h5B
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t      state;
    logic [7:0]  opcode;
    logic [7:0]  len_lo;
    logic [15:0] rem;         // payload bytes still expected
    logic [23:0] word;        // lower three bytes of the operand being assembled
    logic [1:0]  bidx;        // byte position within the current operand
    logic        first_word;
    logic [31:0] acc;
    logic [1:0]  ridx;        // response byte currently presented
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        error;

    logic [15:0] len_full;
    logic [15:0] len_pay;
    logic [31:0] full_word;
    logic [31:0] acc_next;
    logic        handshake;
    logic        is_arith;

    assign len_full  = {rx_data_i, len_lo};
    assign len_pay   = len_full - 16'd4;
    assign full_word = {rx_data_i, word};
    assign handshake = tx_valid && tx_ready_i;
    assign is_arith  = (opcode == OPC_ADD) || (opcode == OPC_SUB);

    assign tx_data_o  = tx_data;
    assign tx_valid_o = tx_valid;
    assign busy_o     = (state != S_IDLE);
    assign error_o    = error;

    // Accumulator update applied when the fourth byte of an operand arrives
    always_comb begin
        if (first_word) begin
            acc_next = full_word;
        end else if (opcode == OPC_SUB) begin
            acc_next = acc - full_word;
        end else begin
            acc_next = acc + full_word;
        end
    end

    // Packet parser, executor and response sequencer
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            opcode     <= '0;
            len_lo     <= '0;
            rem        <= '0;
            word       <= '0;
            bidx       <= '0;
            first_word <= 1'b1;
            acc        <= '0;
            ridx       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            error      <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid_i) begin
                        opcode <= rx_data_i;
                        state  <= S_RSVD;
                    end
                end
                S_RSVD: begin
                    if (rx_valid_i) state <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (rx_valid_i) begin
                        len_lo <= rx_data_i;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (rx_valid_i) begin
                        rem        <= len_pay;
                        bidx       <= '0;
                        word       <= '0;
                        first_word <= 1'b1;
                        acc        <= '0;
                        if (len_full < 16'd4) begin
                            error <= 1'b1;
                            state <= S_IDLE;
                        end else if (len_full == 16'd4) begin
                            state <= S_IDLE;
                        end else if (opcode == OPC_ECHO) begin
                            state <= S_PAYLOAD;
                        end else if (is_arith) begin
                            if ((len_pay[1:0] != 2'd0) || (len_full < 16'd12)) begin
                                error <= 1'b1;
                                state <= S_DRAIN;
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end else begin
                            error <= 1'b1;
                            state <= S_DRAIN;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (opcode == OPC_ECHO) begin
                        // A new byte may refill the hold in the same cycle the old one leaves
                        if (rx_valid_i && (rem != 16'd0)) begin
                            rem <= rem - 16'd1;
                            if (!tx_valid || tx_ready_i) begin
                                tx_data  <= rx_data_i;
                                tx_valid <= 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                        end else begin
                            if (rx_valid_i) error <= 1'b1;
                            if (handshake) tx_valid <= 1'b0;
                            if ((rem == 16'd0) && (!tx_valid || tx_ready_i)) state <= S_IDLE;
                        end
                    end else if (rx_valid_i) begin
                        rem  <= rem - 16'd1;
                        bidx <= bidx + 2'd1;
                        case (bidx)
                            2'd0: word[7:0]   <= rx_data_i;
                            2'd1: word[15:8]  <= rx_data_i;
                            2'd2: word[23:16] <= rx_data_i;
                            default: begin
                                acc        <= acc_next;
                                first_word <= 1'b0;
                            end
                        endcase
                        // Payload is a whole number of words, so the last byte always completes one
                        if (rem == 16'd1) begin
                            state    <= S_RESP;
                            ridx     <= '0;
                            tx_data  <= acc_next[7:0];
                            tx_valid <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rx_valid_i) begin
                        rem <= rem - 16'd1;
                        if (rem == 16'd1) state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (rx_valid_i) error <= 1'b1;
                    if (handshake) begin
                        ridx <= ridx + 2'd1;
                        case (ridx)
                            2'd0: tx_data <= acc[15:8];
                            2'd1: tx_data <= acc[23:16];
                            2'd2: tx_data <= acc[31:24];
                            default: begin
                                tx_valid <= 1'b0;
                                state    <= S_IDLE;
                            end
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Testbench for alu_packet_engine: directed scenarios plus randomized packets
// checked against a packet-level reference model.
module tb_alu_packet_engine;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       error_o;

    int total;
    int bad;

    logic [7:0] pkt_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    int         exp_err;
    int         err_cnt;
    bit         rnd_ready;
    bit         stall;

    alu_packet_engine #(
        .OPC_ECHO(8'hEC),
        .OPC_ADD (8'hAD),
        .OPC_SUB (8'h5B)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rx_data_i (rx_data_i),
        .rx_valid_i(rx_valid_i),
        .tx_data_o (tx_data_o),
        .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),
        .busy_o    (busy_o),
        .error_o   (error_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Transmitter ready: stalled, randomly throttled, or always ready
    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (stall) tx_ready_i = 1'b0;
            else if (rnd_ready) tx_ready_i = ($urandom_range(0, 2) != 0);
            else tx_ready_i = 1'b1;
        end
    end

    // Monitor: collect transferred bytes and error pulses between edges
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i && tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
            if (error_o) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected response bytes and error pulses for pkt_q
    task automatic model();
        int         len;
        logic [7:0] op;
        logic [31:0] acc;
        logic [31:0] w;
        exp_q.delete();
        exp_err = 0;
        op  = pkt_q[0];
        len = int'({pkt_q[3], pkt_q[2]});
        acc = 0;
        if (len < 4) begin
            exp_err = 1;
        end else if (len == 4) begin
            exp_err = 0;
        end else if (op == 8'hEC) begin
            for (int i = 4; i < len; i++) exp_q.push_back(pkt_q[i]);
        end else if (op == 8'hAD || op == 8'h5B) begin
            if (((len - 4) % 4 != 0) || len < 12) begin
                exp_err = 1;
            end else begin
                for (int k = 0; k < (len - 4) / 4; k++) begin
                    w = {pkt_q[4*k+7], pkt_q[4*k+6], pkt_q[4*k+5], pkt_q[4*k+4]};
                    if (k == 0) acc = w;
                    else if (op == 8'hAD) acc = acc + w;
                    else acc = acc - w;
                end
                for (int b = 0; b < 4; b++) exp_q.push_back(8'(acc >> (8 * b)));
            end
        end else begin
            exp_err = 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_i);
        #1;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk_i);
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt_q.size(); i++) send_byte(pkt_q[i]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk_i);
        while ((busy_o || tx_valid_o) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 3000) check({tag, "_timeout"}, 32'(n), 32'd0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 32'(tx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            check({tag, "_byte"}, 32'(tx_q[i]), 32'(exp_q[i]));
        check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
        tx_q.delete();
        err_cnt = 0;
    endtask

    task automatic run_pkt(input string tag);
        model();
        tx_q.delete();
        err_cnt = 0;
        send_pkt();
        wait_idle(tag);
        compare(tag);
    endtask

    task automatic load(input logic [7:0] b[]);
        pkt_q.delete();
        foreach (b[i]) pkt_q.push_back(b[i]);
    endtask

    task automatic rand_pkt();
        int         sel;
        int         len;
        logic [7:0] op;
        sel = $urandom_range(0, 3);
        if (sel == 0) op = 8'hEC;
        else if (sel == 1) op = 8'hAD;
        else if (sel == 2) op = 8'h5B;
        else begin
            op = 8'($urandom_range(0, 255));
            while (op == 8'hEC || op == 8'hAD || op == 8'h5B) op = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 4);
        else if (sel == 0) len = $urandom_range(5, 12);
        else if (sel == 3) len = $urandom_range(5, 10);
        else if ($urandom_range(0, 4) == 0) len = $urandom_range(5, 14);
        else len = 12 + 4 * $urandom_range(0, 3);
        pkt_q.delete();
        pkt_q.push_back(op);
        pkt_q.push_back(8'($urandom_range(0, 255)));
        pkt_q.push_back(8'(len));
        pkt_q.push_back(8'(len >> 8));
        for (int i = 4; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
        rnd_ready = (sel == 1 || sel == 2);
    endtask

    initial begin
        int unstable;
        int n;
        total      = 0;
        bad        = 0;
        err_cnt    = 0;
        rnd_ready  = 0;
        stall      = 0;
        rst_i      = 1'b0;
        rx_data_i  = '0;
        rx_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_txv", 32'(tx_valid_o), 32'd0);
        check("rst_txd", 32'(tx_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(error_o), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        // T1 echo
        load('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42});
        run_pkt("t1");
        check("t1_busy", 32'(busy_o), 32'd0);

        // T2 add
        load('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
        run_pkt("t2");

        // T3 add with wrap and a long transmitter stall
        load('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00});
        model();
        tx_q.delete();
        err_cnt = 0;
        stall = 1;
        repeat (2) @(posedge clk_i);
        send_pkt();
        n = 0;
        @(negedge clk_i);
        while (!tx_valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("t3_valid", 32'(tx_valid_o), 32'd1);
        unstable = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (!tx_valid_o || tx_data_o !== 8'h01) unstable++;
        end
        check("t3_hold", 32'(unstable), 32'd0);
        stall = 0;
        wait_idle("t3");
        compare("t3");

        // T4 sub
        load('{8'h5B, 8'h00, 8'h10, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
        run_pkt("t4");

        // T5 unknown opcode, bad ADD length, then a good echo
        load('{8'h77, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
        run_pkt("t5a");
        load('{8'hAD, 8'h00, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        run_pkt("t5b");
        load('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42});
        run_pkt("t5c");

        // Short length and header-only packet
        load('{8'hEC, 8'h00, 8'h03, 8'h00});
        run_pkt("len3");
        load('{8'hAD, 8'h00, 8'h04, 8'h00});
        run_pkt("len4");

        // T6 reset mid-packet
        for (int i = 0; i < 6; i++) send_byte(i < 4 ? 8'(i == 0 ? 8'hAD : (i == 2 ? 8'h0C : 8'h00)) : 8'(i == 4 ? 1 : 0));
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("t6_txv", 32'(tx_valid_o), 32'd0);
        check("t6_txd", 32'(tx_data_o), 32'd0);
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_err", 32'(error_o), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        load('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
        run_pkt("t6");

        // Randomized packets
        for (int p = 0; p < 40; p++) begin
            rand_pkt();
            run_pkt("rnd");
            rnd_ready = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
